mpc_sample_launch: RTL

Initiator side of the MPC solver handshake: a periodic sequencer that samples plant measurements on every control period and pulses the solver start. It then waits for the solver's done, saturates the returned actuation, and presents it with a one-cycle valid strobe. The downstream valid/hold stage latches that value and holds it between updates. It sits between the ADC/encoder front end and the implicit-MPC core, and owns the control-period timebase.

---
 rtl/mpc_pkg.sv | 31 +++
 rtl/mpc_period_timer.sv | 39 +++
 rtl/mpc_sample_launch.sv | 156 +++++++++++++++
 3 files changed

// File: rtl/mpc_pkg.sv
// Shared types for the MPC sample/launch sequencer: FSM state encoding,
// default word width, and the symmetric actuation clamp.
package mpc_pkg;

  localparam int DATA_W_DEFAULT = 21;
  localparam int SAT_W          = 64;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    WAIT  = 2'd2,
    EMIT  = 2'd3
  } state_t;

  // Callers sign-extend into SAT_W bits, so the comparisons against +/-lim
  // cannot overflow for any DATA_W up to 63.
  function automatic logic signed [SAT_W-1:0] saturate(
    input logic signed [SAT_W-1:0] v,
    input logic signed [SAT_W-1:0] lim
  );
    logic signed [SAT_W-1:0] res;
    res = v;
    if (v > lim) begin
      res = lim;
    end else if (v < -lim) begin
      res = -lim;
    end
    return res;
  endfunction

endpackage

// File: rtl/mpc_period_timer.sv
// Control-period timebase: free-running 0..PERIOD-1 counter, advancing only on ce_1.
// tick is combinational (last count and ce_1 high); no backpressure, never stalls.
module mpc_period_timer
  import mpc_pkg::*;
#(
  parameter int PERIOD = 1000
) (
  input  logic clk_1,
  input  logic rst_1,
  input  logic ce_1,
  output logic tick
);

  localparam int CNT_W = (PERIOD > 1) ? $clog2(PERIOD) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(PERIOD - 1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic             at_last;

  always_comb begin
    at_last = (cnt_q == CNT_LAST);
    cnt_d   = cnt_q;
    if (ce_1) begin
      cnt_d = at_last ? '0 : cnt_q + 1'b1;
    end
  end

  assign tick = at_last & ce_1;

  always_ff @(posedge clk_1 or posedge rst_1) begin
    if (rst_1) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/mpc_sample_launch.sv
// Periodic sampler and solver launcher; tick->start 1 cycle, done->u_valid 1 cycle (ce_1 cycles).
// No backpressure: ticks arriving while busy are dropped and counted. Option: MPC_LAUNCH_TIMEOUT_EN.
module mpc_sample_launch
  import mpc_pkg::*;
#(
  parameter int                        DATA_W  = DATA_W_DEFAULT,
  parameter int                        PERIOD  = 1000,
  parameter logic signed [DATA_W-1:0]  U_MAX   = 21'sd524287,
  parameter int                        TIMEOUT = 900
) (
  input  logic              clk_1,
  input  logic              rst_1,
  input  logic              ce_1,
  input  logic [DATA_W-1:0] meas0_in,
  input  logic [DATA_W-1:0] meas1_in,
  output logic [DATA_W-1:0] x0_out,
  output logic [DATA_W-1:0] x1_out,
  output logic              solver_start,
  input  logic              solver_done,
  input  logic [DATA_W-1:0] u_in,
  output logic [DATA_W-1:0] u_out,
  output logic              u_valid,
  output logic [7:0]        miss_cnt
`ifdef MPC_LAUNCH_TIMEOUT_EN
  ,
  output logic              overrun
`endif
);

  if (PERIOD < 8) begin : g_bad_period
    $error("mpc_sample_launch: PERIOD must be at least 8");
  end
  if (U_MAX <= 0) begin : g_bad_umax
    $error("mpc_sample_launch: U_MAX must be positive");
  end
  if (TIMEOUT < 1 || TIMEOUT >= PERIOD - 3) begin : g_bad_timeout
    $error("mpc_sample_launch: TIMEOUT must be in 1..PERIOD-4");
  end

  logic tick;

  mpc_period_timer #(
    .PERIOD(PERIOD)
  ) u_timer (
    .clk_1(clk_1),
    .rst_1(rst_1),
    .ce_1 (ce_1),
    .tick (tick)
  );

  state_t            state_q, state_d;
  logic [DATA_W-1:0] x0_q, x0_d;
  logic [DATA_W-1:0] x1_q, x1_d;
  logic [DATA_W-1:0] u_q, u_d;
  logic [7:0]        miss_q, miss_d;
  logic [DATA_W-1:0] u_sat;

`ifdef MPC_LAUNCH_TIMEOUT_EN
  localparam int WAIT_W = $clog2(TIMEOUT + 1);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT - 1);

  logic [WAIT_W-1:0] wait_q, wait_d;
  logic              ovr_q, ovr_d;
`endif

  assign u_sat = DATA_W'(saturate(SAT_W'($signed(u_in)), SAT_W'(U_MAX)));

  always_comb begin
    state_d = state_q;
    x0_d    = x0_q;
    x1_d    = x1_q;
    u_d     = u_q;
    miss_d  = miss_q;
`ifdef MPC_LAUNCH_TIMEOUT_EN
    wait_d  = wait_q;
    ovr_d   = ovr_q;
`endif
    if (ce_1) begin
      // Any tick that finds the sequencer busy is lost; the count sticks at 255.
      if (tick && (state_q != IDLE) && (miss_q != 8'hFF)) begin
        miss_d = miss_q + 8'd1;
      end
      case (state_q)
        IDLE: begin
          if (tick) begin
            x0_d    = meas0_in;
            x1_d    = meas1_in;
            state_d = START;
          end
        end
        START: begin
          state_d = WAIT;
`ifdef MPC_LAUNCH_TIMEOUT_EN
          wait_d  = '0;
`endif
        end
        WAIT: begin
          if (solver_done) begin
            u_d     = u_sat;
            state_d = EMIT;
          end
`ifdef MPC_LAUNCH_TIMEOUT_EN
          else if (wait_q == WAIT_LAST) begin
            // Give up on the solver but still strobe, re-presenting the last actuation.
            ovr_d   = 1'b1;
            state_d = EMIT;
          end else begin
            wait_d  = wait_q + 1'b1;
          end
`endif
        end
        EMIT: begin
          state_d = IDLE;
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk_1 or posedge rst_1) begin
    if (rst_1) begin
      state_q <= IDLE;
      x0_q    <= '0;
      x1_q    <= '0;
      u_q     <= '0;
      miss_q  <= '0;
`ifdef MPC_LAUNCH_TIMEOUT_EN
      wait_q  <= '0;
      ovr_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      x0_q    <= x0_d;
      x1_q    <= x1_d;
      u_q     <= u_d;
      miss_q  <= miss_d;
`ifdef MPC_LAUNCH_TIMEOUT_EN
      wait_q  <= wait_d;
      ovr_q   <= ovr_d;
`endif
    end
  end

  assign solver_start = (state_q == START) & ce_1;
  assign u_valid      = (state_q == EMIT) & ce_1;
  assign x0_out       = x0_q;
  assign x1_out       = x1_q;
  assign u_out        = u_q;
  assign miss_cnt     = miss_q;
`ifdef MPC_LAUNCH_TIMEOUT_EN
  assign overrun      = ovr_q;
`endif

endmodule
